axis_byte_packer: RTL



---
 rtl/axis_byte_packer.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/axis_byte_packer.sv
// axis_byte_packer
//   Packs an 8-bit AXI-Stream byte stream into 32-bit little-endian words for
//   the command-word matcher. The first byte of a word lands in [7:0].
//   An inter-byte idle timeout and an explicit flush close partial words, so
//   framing recovers after a lost or extra serial byte. Partial words carry
//   tkeep for the valid lanes and tlast=1.
//
// Ports
//   clk_i            clock, rising edge
//   reset_n_i        asynchronous active-low reset
//   s_axis_tdata_i   input byte
//   s_axis_tvalid_i  input byte valid
//   s_axis_tready_o  input byte ready
//   flush_i          request to emit the pending partial word
//   m_axis_tdata_o   packed word
//   m_axis_tkeep_o   lane valid mask
//   m_axis_tvalid_o  word valid
//   m_axis_tlast_o   word was closed by timeout or flush
//   m_axis_tready_i  downstream ready
module axis_byte_packer #(
  parameter int timeout_cycles_p = 4096
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic [7:0]  s_axis_tdata_i,
  input  logic        s_axis_tvalid_i,
  output logic        s_axis_tready_o,
  input  logic        flush_i,
  output logic [31:0] m_axis_tdata_o,
  output logic [3:0]  m_axis_tkeep_o,
  output logic        m_axis_tvalid_o,
  output logic        m_axis_tlast_o,
  input  logic        m_axis_tready_i
);

  // A zero timeout still needs a 1-bit counter so the vector is legal; it is
  // then held at zero forever.
  localparam int CNT_W = (timeout_cycles_p == 0) ? 1 : $clog2(timeout_cycles_p + 1);
  localparam logic [CNT_W-1:0] CNT_SAT =
    (timeout_cycles_p == 0) ? '0 : CNT_W'(timeout_cycles_p - 1);

  logic [1:0]       idx_q,   idx_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [23:0]      lane_q,  lane_d;     // lanes 0..2; lane 3 goes straight out
  logic [31:0]      odata_q, odata_d;
  logic [3:0]       okeep_q, okeep_d;
  logic             olast_q, olast_d;
  logic             ovld_q,  ovld_d;

  logic out_free;
  logic byte_hs;
  logic timeout_hit;
  logic flush_fire;

  // The output slot can accept a new word when empty or draining this cycle.
  assign out_free        = !ovld_q || m_axis_tready_i;
  assign s_axis_tready_o = reset_n_i && ((idx_q != 2'd3) || out_free);
  assign byte_hs         = s_axis_tvalid_i && s_axis_tready_o;
  assign timeout_hit     = (timeout_cycles_p != 0) && (cnt_q == CNT_SAT);
  // A byte handshake always wins over flush/timeout in the same cycle.
  assign flush_fire      = (idx_q != 2'd0) && !byte_hs &&
                           (flush_i || timeout_hit) && out_free;

  assign m_axis_tdata_o  = odata_q;
  assign m_axis_tkeep_o  = okeep_q;
  assign m_axis_tlast_o  = olast_q;
  assign m_axis_tvalid_o = ovld_q;

  always_comb begin
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    lane_d  = lane_q;
    odata_d = odata_q;
    okeep_d = okeep_q;
    olast_d = olast_q;
    ovld_d  = ovld_q;

    // Drain: a held word leaves when downstream takes it.
    if (ovld_q && m_axis_tready_i) begin
      ovld_d = 1'b0;
    end

    if (byte_hs) begin
      cnt_d = '0;
      case (idx_q)
        2'd0: begin lane_d[7:0]   = s_axis_tdata_i; idx_d = 2'd1; end
        2'd1: begin lane_d[15:8]  = s_axis_tdata_i; idx_d = 2'd2; end
        2'd2: begin lane_d[23:16] = s_axis_tdata_i; idx_d = 2'd3; end
        default: begin
          // Fourth byte: the word completes on this edge. Lanes are cleared
          // so a later partial word never carries stale bytes.
          odata_d = {s_axis_tdata_i, lane_q};
          okeep_d = 4'hF;
          olast_d = 1'b0;
          ovld_d  = 1'b1;
          lane_d  = '0;
          idx_d   = 2'd0;
        end
      endcase
    end else if (flush_fire) begin
      // Unused lanes are already zero because lanes clear on every emit.
      odata_d = {8'h00, lane_q};
      case (idx_q)
        2'd1:    okeep_d = 4'b0001;
        2'd2:    okeep_d = 4'b0011;
        default: okeep_d = 4'b0111;
      endcase
      olast_d = 1'b1;
      ovld_d  = 1'b1;
      lane_d  = '0;
      idx_d   = 2'd0;
      cnt_d   = '0;
    end else if (idx_q == 2'd0) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_SAT) begin
      // Saturates so a blocked timeout keeps retrying until the output frees.
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      idx_q   <= 2'd0;
      cnt_q   <= '0;
      lane_q  <= '0;
      odata_q <= '0;
      okeep_q <= '0;
      olast_q <= 1'b0;
      ovld_q  <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      lane_q  <= lane_d;
      odata_q <= odata_d;
      okeep_q <= okeep_d;
      olast_q <= olast_d;
      ovld_q  <= ovld_d;
    end
  end

endmodule
